// File: rtl/credit_loop_controller_mc.sv
// credit_loop_controller_mc: sideband RDI credit loop (return pulses + adapter credit count).
// Optional sticky error flag enabled by defining CRD_LOOP_ERR_EN.
module credit_loop_controller_mc #(
    parameter int                 NUM_SRC      = 4,
    parameter logic [NUM_SRC-1:0] CRD_SRC_MASK = 4'b1110,
    parameter int                 CRD_DEPTH    = 32,
    parameter int                 RET_Q_DEPTH  = 8,
    localparam int                SW           = $clog2(NUM_SRC),
    localparam int                CW           = $clog2(CRD_DEPTH + 1),
    localparam int                QW           = $clog2(RET_Q_DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_tx_fifo_read_en,
    input  logic [SW-1:0] i_srcid,
    input  logic          i_fifo_data_is_zeros,
    input  logic          i_lp_cfg_crd,
    input  logic          i_rising_edge_pl_cfg_vld,
    input  logic          i_err_clr,
    output logic          o_pl_cfg_crd,
    output logic          o_adapter_is_full,
    output logic [CW-1:0] o_crd_cnt,
    output logic [QW-1:0] o_ret_pending,
    output logic          o_crd_err
);
    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_e;
    state_e        state_q, state_d;
    logic [QW-1:0] pend_q, pend_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_q, full_q;
    logic          inc, dec, ret_ovf, crd_ovf, crd_udf, lp_only, vld_only;
    always_comb begin
        inc      = i_tx_fifo_read_en & ~i_fifo_data_is_zeros & CRD_SRC_MASK[i_srcid];
        dec      = (state_q == PULSE);
        ret_ovf  = inc & ~dec & (pend_q == QW'(RET_Q_DEPTH));
        pend_d   = (inc & ~dec & ~ret_ovf) ? pend_q + QW'(1) :
                   (dec & ~inc)            ? pend_q - QW'(1) : pend_q;
        // IDLE and GAP share the same exit rule; PULSE always inserts a gap.
        state_d  = (state_q == PULSE) ? GAP : (pend_q != '0) ? PULSE : IDLE;
        lp_only  = i_lp_cfg_crd & ~i_rising_edge_pl_cfg_vld;
        vld_only = i_rising_edge_pl_cfg_vld & ~i_lp_cfg_crd;
        crd_ovf  = lp_only & (cnt_q == CW'(CRD_DEPTH));
        crd_udf  = vld_only & (cnt_q == '0);
        cnt_d    = (lp_only & ~crd_ovf)  ? cnt_q + CW'(1) :
                   (vld_only & ~crd_udf) ? cnt_q - CW'(1) : cnt_q;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            cnt_q   <= CW'(CRD_DEPTH);
            pulse_q <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            pulse_q <= (state_d == PULSE);
            full_q  <= (cnt_d == '0);
        end
    end
`ifdef CRD_LOOP_ERR_EN
    logic err_q, err_d;
    // A new error outranks a simultaneous clear.
    assign err_d = ret_ovf | crd_ovf | crd_udf | (err_q & ~i_err_clr);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) err_q <= 1'b0;
        else          err_q <= err_d;
    end
    assign o_crd_err = err_q;
`else
    logic unused_err;
    assign unused_err = ^{i_err_clr, ret_ovf, crd_ovf, crd_udf};
    assign o_crd_err  = 1'b0;
`endif
    assign o_pl_cfg_crd      = pulse_q;
    assign o_adapter_is_full = full_q;
    assign o_crd_cnt         = cnt_q;
    assign o_ret_pending     = pend_q;
endmodule
